// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared constants, mixer state encoding and arithmetic helpers for the PSG mixer
package psg_pkg;

  localparam int PAN_L = 0;
  localparam int PAN_R = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2
  } mix_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Clamp a wide signed value into the range of a signed word of the given width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/tt_um_accelshark_psg_mac.sv
// rtl/tt_um_accelshark_psg_mac.sv - one channel accumulator: gated add of a shared signed product
module tt_um_accelshark_psg_mac #(
  parameter int PROD_W = 21,
  parameter int ACC_W  = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ena_i,
  input  logic                     clr_i,
  input  logic                     add_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] prod_x;

  assign prod_x = ACC_W'(prod_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + prod_x;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (ena_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/tt_um_accelshark_psg_mixer_seq.sv
// rtl/tt_um_accelshark_psg_mixer_seq.sv - time-multiplexed stereo voice mixer, one voice per cycle
module tt_um_accelshark_psg_mixer_seq
  import psg_pkg::*;
#(
  parameter int VOICES   = 4,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       start,
  input  logic [VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [VOICES*VOL_W-1:0]    voice_volume,
  input  logic [VOICES*2-1:0]        voice_pan,
  input  logic [1:0]                 master_atten,
  output logic signed [SAMPLE_W-1:0] mix_l,
  output logic signed [SAMPLE_W-1:0] mix_r,
  output logic                       mix_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int IDX_W  = (clog2(VOICES) > 0) ? clog2(VOICES) : 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam int ACC_W  = PROD_W + clog2(VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

  mix_state_e state_q, state_d;
  logic       accept, step, finish;

  logic [VOICES*SAMPLE_W-1:0] snap_sample_q;
  logic [VOICES*VOL_W-1:0]    snap_vol_q;
  logic [VOICES*2-1:0]        snap_pan_q;
  logic [1:0]                 atten_q;
  logic [IDX_W-1:0]           idx_q;

  logic signed [SAMPLE_W-1:0] mix_l_q, mix_r_q;
  logic                       mix_valid_q, overrun_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // The product is formed once from the snapshot and shared by both channels.
  logic signed [SAMPLE_W-1:0] sample_cur;
  logic [VOL_W-1:0]           vol_cur;
  logic [1:0]                 pan_cur;
  logic signed [PROD_W-1:0]   samp_x, vol_x, prod;

  assign sample_cur = snap_sample_q[idx_q*SAMPLE_W +: SAMPLE_W];
  assign vol_cur    = snap_vol_q[idx_q*VOL_W +: VOL_W];
  assign pan_cur    = snap_pan_q[idx_q*2 +: 2];
  assign samp_x     = PROD_W'(sample_cur);
  assign vol_x      = {{(SAMPLE_W + 1){1'b0}}, vol_cur};
  assign prod       = samp_x * vol_x;

  logic signed [ACC_W-1:0] acc_l, acc_r;

  tt_um_accelshark_psg_mac #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_mac_l (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ena_i  (ena),
    .clr_i  (accept),
    .add_i  (step && pan_cur[PAN_L]),
    .prod_i (prod),
    .acc_o  (acc_l)
  );

  tt_um_accelshark_psg_mac #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_mac_r (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ena_i  (ena),
    .clr_i  (accept),
    .add_i  (step && pan_cur[PAN_R]),
    .prod_i (prod),
    .acc_o  (acc_r)
  );

  // Volume scale and master attenuation fold into one floor-rounding arithmetic shift.
  logic [7:0]         shamt;
  logic signed [63:0] wide_l, wide_r, sh_l, sh_r;

  assign shamt  = 8'(VOL_W) + {6'b0, atten_q};
  assign wide_l = 64'(acc_l);
  assign wide_r = 64'(acc_r);
  assign sh_l   = wide_l >>> shamt;
  assign sh_r   = wide_r >>> shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_sample_q <= '0;
      snap_vol_q    <= '0;
      snap_pan_q    <= '0;
      atten_q       <= '0;
      idx_q         <= '0;
      mix_l_q       <= '0;
      mix_r_q       <= '0;
      mix_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else if (ena) begin
      mix_valid_q <= finish;
      if (accept) begin
        snap_sample_q <= voice_sample;
        snap_vol_q    <= voice_volume;
        snap_pan_q    <= voice_pan;
        atten_q       <= master_atten;
        idx_q         <= '0;
      end else if (step) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      if (finish) begin
        mix_l_q <= SAMPLE_W'(saturate(sh_l, SAMPLE_W));
        mix_r_q <= SAMPLE_W'(saturate(sh_r, SAMPLE_W));
      end
      if (start && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign mix_l     = mix_l_q;
  assign mix_r     = mix_r_q;
  assign mix_valid = mix_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule
